instr_fetch_ctrl: RTL and testbench

//   Fetch sequencer for the instruction memory. Owns the fetch PC and drives
//   the 8-bit word address into instr_memory, which reads combinationally.

---
 rtl/instr_fetch_ctrl.sv | 97 +++++++++
 tb/tb_instr_fetch_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, addresses instruction memory and buffers
// fetched words in a 2-entry FIFO handed to decode over valid/ready.
module instr_fetch_ctrl #(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_in,
    input  logic              stop_in,
    input  logic              branch_valid_in,
    input  logic [ADDR_W-1:0] branch_target_in,
    output logic [ADDR_W-1:0] instr_ddr_out,
    input  logic [DATA_W-1:0] instr_data_in,
    output logic              instr_valid_out,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] instr_pc_out,
    input  logic              instr_ready_in,
    output logic              busy_out
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]        state;
    logic [0:0]        state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [1:0]        count;
    logic [1:0]        count_after_pop;
    logic [DATA_W-1:0] head_data;
    logic [ADDR_W-1:0] head_pc;
    logic [DATA_W-1:0] tail_data;
    logic [ADDR_W-1:0] tail_pc;
    logic              pop;
    logic              push;

    // Head slot doubles as the output register, so it simply holds when empty.
    always_comb begin
        pop             = (count != 2'd0) && instr_ready_in;
        push            = (state == ST_RUN) && !stop_in && !branch_valid_in &&
                          ((count < 2'd2) || pop);
        count_after_pop = count - {1'b0, pop};
    end

    always_comb begin
        state_nxt = state;
        if ((state == ST_IDLE) && start_in) begin
            state_nxt = ST_RUN;
        end else if ((state == ST_RUN) && stop_in) begin
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            pc        <= RESET_PC;
            count     <= 2'd0;
            head_data <= '0;
            head_pc   <= '0;
            tail_data <= '0;
            tail_pc   <= '0;
        end else begin
            state <= state_nxt;
            if (branch_valid_in) begin
                // Flush discards buffered words, including one being popped now.
                pc    <= branch_target_in;
                count <= 2'd0;
            end else begin
                count <= count_after_pop + {1'b0, push};
                if (pop && (count == 2'd2)) begin
                    head_data <= tail_data;
                    head_pc   <= tail_pc;
                end
                if (push) begin
                    pc <= pc + PC_STEP;
                    if (count_after_pop == 2'd0) begin
                        head_data <= instr_data_in;
                        head_pc   <= pc;
                    end else begin
                        tail_data <= instr_data_in;
                        tail_pc   <= pc;
                    end
                end
            end
        end
    end

    assign instr_ddr_out   = pc;
    assign instr_valid_out = (count != 2'd0);
    assign instr_out       = head_data;
    assign instr_pc_out    = head_pc;
    assign busy_out        = (state == ST_RUN);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: fixed vector table, directed corner sequences,
// and random traffic against a queue-based reference model.
module tb_instr_fetch_ctrl;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_in;
    logic              stop_in;
    logic              branch_valid_in;
    logic [ADDR_W-1:0] branch_target_in;
    logic [ADDR_W-1:0] instr_ddr_out;
    logic [DATA_W-1:0] instr_data_in;
    logic              instr_valid_out;
    logic [DATA_W-1:0] instr_out;
    logic [ADDR_W-1:0] instr_pc_out;
    logic              instr_ready_in;
    logic              busy_out;

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] memWord(logic [ADDR_W-1:0] a);
        return 32'h0000_1000 + 32'(a);
    endfunction

    assign instr_data_in = memWord(instr_ddr_out);

    instr_fetch_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .start_in         (start_in),
        .stop_in          (stop_in),
        .branch_valid_in  (branch_valid_in),
        .branch_target_in (branch_target_in),
        .instr_ddr_out    (instr_ddr_out),
        .instr_data_in    (instr_data_in),
        .instr_valid_out  (instr_valid_out),
        .instr_out        (instr_out),
        .instr_pc_out     (instr_pc_out),
        .instr_ready_in   (instr_ready_in),
        .busy_out         (busy_out)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] data;
    } entry_t;

    typedef struct {
        logic              rst;
        logic              start;
        logic              stop;
        logic              br;
        logic [ADDR_W-1:0] tgt;
        logic              rdy;
        logic              e_valid;
        logic [ADDR_W-1:0] e_pc;
        logic [DATA_W-1:0] e_instr;
        logic              e_busy;
        logic [ADDR_W-1:0] e_ddr;
    } vec_t;

    entry_t            mq[$];
    logic              mrun;
    logic [ADDR_W-1:0] mpc;
    logic [ADDR_W-1:0] last_pc;
    logic [DATA_W-1:0] last_instr;
    int                checks = 0;
    int                errors = 0;

    task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: a queue of {pc, word}, a run flag and a PC, advanced once per edge.
    task automatic modelStep();
        entry_t e;
        logic   do_pop;
        logic   do_push;
        if (rst) begin
            mq.delete();
            mrun       = 1'b0;
            mpc        = '0;
            last_pc    = '0;
            last_instr = '0;
        end else begin
            do_pop  = (mq.size() > 0) && instr_ready_in;
            do_push = mrun && !stop_in && !branch_valid_in && ((mq.size() < 2) || do_pop);
            if (branch_valid_in) begin
                mq.delete();
                mpc = branch_target_in;
            end else begin
                if (do_pop) void'(mq.pop_front());
                if (do_push) begin
                    e.pc   = mpc;
                    e.data = memWord(mpc);
                    mq.push_back(e);
                    mpc = mpc + 8'd1;
                end
            end
            if (!mrun && start_in) mrun = 1'b1;
            else if (mrun && stop_in) mrun = 1'b0;
            if (mq.size() > 0) begin
                last_pc    = mq[0].pc;
                last_instr = mq[0].data;
            end
        end
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic p, input logic b,
                                 input logic [ADDR_W-1:0] t, input logic rdy);
        rst              = r;
        start_in         = s;
        stop_in          = p;
        branch_valid_in  = b;
        branch_target_in = t;
        instr_ready_in   = rdy;
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic checkOutput();
        checkValue("model_valid", 32'(instr_valid_out), 32'(mq.size() > 0));
        checkValue("model_pc_out", 32'(instr_pc_out), 32'(last_pc));
        checkValue("model_instr", instr_out, last_instr);
        checkValue("model_busy", 32'(busy_out), 32'(mrun));
        checkValue("model_ddr", 32'(instr_ddr_out), 32'(mpc));
    endtask

    task automatic step(input logic r, input logic s, input logic p, input logic b,
                        input logic [ADDR_W-1:0] t, input logic rdy);
        applyStimulus(r, s, p, b, t, rdy);
        checkOutput();
    endtask

    vec_t vecs[14];

    initial begin
        rst = 1'b1; start_in = 1'b0; stop_in = 1'b0; branch_valid_in = 1'b0;
        branch_target_in = '0; instr_ready_in = 1'b0;
        mrun = 1'b0; mpc = '0; last_pc = '0; last_instr = '0;

        // Start, stall to full, drain, stop and restart at the frozen PC.
        vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,8'h00,1'b0, 1'b0,8'h00,32'h0000_0000,1'b0,8'h00};
        vecs[1]  = '{1'b0,1'b1,1'b0,1'b0,8'h00,1'b1, 1'b0,8'h00,32'h0000_0000,1'b1,8'h00};
        vecs[2]  = '{1'b0,1'b0,1'b0,1'b0,8'h00,1'b1, 1'b1,8'h00,32'h0000_1000,1'b1,8'h01};
        vecs[3]  = '{1'b0,1'b0,1'b0,1'b0,8'h00,1'b1, 1'b1,8'h01,32'h0000_1001,1'b1,8'h02};
        vecs[4]  = '{1'b0,1'b0,1'b0,1'b0,8'h00,1'b0, 1'b1,8'h01,32'h0000_1001,1'b1,8'h03};
        vecs[5]  = '{1'b0,1'b0,1'b0,1'b0,8'h00,1'b0, 1'b1,8'h01,32'h0000_1001,1'b1,8'h03};
        vecs[6]  = '{1'b0,1'b0,1'b0,1'b0,8'h00,1'b0, 1'b1,8'h01,32'h0000_1001,1'b1,8'h03};
        vecs[7]  = '{1'b0,1'b0,1'b0,1'b0,8'h00,1'b1, 1'b1,8'h02,32'h0000_1002,1'b1,8'h04};
        vecs[8]  = '{1'b0,1'b0,1'b0,1'b0,8'h00,1'b1, 1'b1,8'h03,32'h0000_1003,1'b1,8'h05};
        vecs[9]  = '{1'b0,1'b0,1'b1,1'b0,8'h00,1'b1, 1'b1,8'h04,32'h0000_1004,1'b0,8'h05};
        vecs[10] = '{1'b0,1'b0,1'b0,1'b0,8'h00,1'b1, 1'b0,8'h04,32'h0000_1004,1'b0,8'h05};
        vecs[11] = '{1'b0,1'b0,1'b0,1'b0,8'h00,1'b1, 1'b0,8'h04,32'h0000_1004,1'b0,8'h05};
        vecs[12] = '{1'b0,1'b1,1'b0,1'b0,8'h00,1'b0, 1'b0,8'h04,32'h0000_1004,1'b1,8'h05};
        vecs[13] = '{1'b0,1'b0,1'b0,1'b0,8'h00,1'b1, 1'b1,8'h05,32'h0000_1005,1'b1,8'h06};

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].start, vecs[i].stop, vecs[i].br,
                          vecs[i].tgt, vecs[i].rdy);
            checkValue("vec_valid", 32'(instr_valid_out), 32'(vecs[i].e_valid));
            checkValue("vec_pc_out", 32'(instr_pc_out), 32'(vecs[i].e_pc));
            checkValue("vec_instr", instr_out, vecs[i].e_instr);
            checkValue("vec_busy", 32'(busy_out), 32'(vecs[i].e_busy));
            checkValue("vec_ddr", 32'(instr_ddr_out), 32'(vecs[i].e_ddr));
            checkOutput();
        end

        // Branch while full and popping: flush, then target word arrives.
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        checkValue("full_ddr", 32'(instr_ddr_out), 32'h02);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h40, 1'b1);
        checkValue("br_flush_valid", 32'(instr_valid_out), 32'h0);
        checkValue("br_ddr", 32'(instr_ddr_out), 32'h40);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        checkValue("br_target_valid", 32'(instr_valid_out), 32'h1);
        checkValue("br_target_pc", 32'(instr_pc_out), 32'h40);
        checkValue("br_target_instr", instr_out, 32'h0000_1040);

        // PC wrap from 0xFE through 0xFF to 0x00.
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'hFE, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        checkValue("wrap_pc0", 32'(instr_pc_out), 32'hFE);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        checkValue("wrap_pc1", 32'(instr_pc_out), 32'hFF);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        checkValue("wrap_pc2", 32'(instr_pc_out), 32'h00);
        checkValue("wrap_instr2", instr_out, 32'h0000_1000);

        // Stop with two words buffered: drain, frozen PC, resume there.
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        checkValue("stop_busy", 32'(busy_out), 32'h0);
        checkValue("stop_head_pc", 32'(instr_pc_out), 32'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        checkValue("drain_pc1", 32'(instr_pc_out), 32'h01);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        checkValue("drain_empty", 32'(instr_valid_out), 32'h0);
        checkValue("stop_ddr_frozen", 32'(instr_ddr_out), 32'h02);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        checkValue("resume_pc", 32'(instr_pc_out), 32'h02);

        // Reset beats a simultaneous branch while full.
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h77, 1'b0);
        checkValue("rst_busy", 32'(busy_out), 32'h0);
        checkValue("rst_valid", 32'(instr_valid_out), 32'h0);
        checkValue("rst_ddr", 32'(instr_ddr_out), 32'h00);

        // Random traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(99) < 1),
                 1'($urandom_range(99) < 10),
                 1'($urandom_range(99) < 7),
                 1'($urandom_range(99) < 8),
                 8'($urandom_range(255)),
                 1'($urandom_range(99) < 70));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
